// File: rtl/prefix_iter_sequencer.sv
// Time-multiplexed Kogge-Stone adder: one black-cell prefix row per clock over
// registered generate/propagate vectors, with valid/ready handshakes on both sides.
module prefix_iter_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [WIDTH-1:0]                    a,
  input  logic [WIDTH-1:0]                    b,
  input  logic                                cin,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [WIDTH-1:0]                    sum,
  output logic                                cout,
  output logic                                busy,
  output logic [$clog2($clog2(WIDTH)):0]      level
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int LW     = $clog2(LEVELS) + 1;

  typedef enum logic [1:0] {IDLE, PREFIX, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] g_r, p_r, pbase_r;
  logic             cin_r;
  logic             load, step, last;
  logic [WIDTH-1:0] g_load, g_step, p_step, g_sh, p_sh, hi_mask;
  int unsigned      span;

  assign last = (level == LW'(LEVELS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load       = 1'b1;
          state_next = PREFIX;
        end
      end
      PREFIX: begin
        step = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        // Retire and reload on the same edge so back-to-back ops skip IDLE.
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) begin
            load       = 1'b1;
            state_next = PREFIX;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Carry-in folds into bit 0's generate so the prefix tree needs no extra column.
  always_comb begin
    g_load    = a & b;
    g_load[0] = (a[0] & b[0]) | ((a[0] ^ b[0]) & cin);
  end

  // Bits below the span see zeros from the shift, so G holds there; P is masked explicitly.
  always_comb begin
    span    = 32'd1 << level;
    g_sh    = g_r << span;
    p_sh    = p_r << span;
    hi_mask = '1;
    hi_mask = hi_mask << span;
    g_step  = g_r | (p_r & g_sh);
    p_step  = p_r & (p_sh | ~hi_mask);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_r     <= '0;
      p_r     <= '0;
      pbase_r <= '0;
      cin_r   <= 1'b0;
      level   <= '0;
    end else if (load) begin
      g_r     <= g_load;
      p_r     <= a ^ b;
      pbase_r <= a ^ b;
      cin_r   <= cin;
      level   <= '0;
    end else if (step) begin
      g_r   <= g_step;
      p_r   <= p_step;
      level <= level + LW'(1);
    end
  end

  always_comb begin
    busy      = (state == PREFIX);
    out_valid = (state == DONE);
    sum       = '0;
    cout      = 1'b0;
    if (state == DONE) begin
      sum  = pbase_r ^ {g_r[WIDTH-2:0], cin_r};
      cout = g_r[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_prefix_iter_sequencer.sv
// Directed and random checks of the iterative prefix adder at WIDTH=16 and WIDTH=8.
module tb_prefix_iter_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [15:0] a, b, sum;
  logic [2:0]  level;

  logic        in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8, busy8;
  logic [7:0]  a8, b8, sum8;
  logic [2:0]  level8;

  int checks = 0;
  int errors = 0;
  int lat;

  always #5 clk = ~clk;

  prefix_iter_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy), .level(level)
  );

  prefix_iter_sequencer #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .busy(busy8), .level(level8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op with out_ready=1; checks busy/level each PREFIX cycle, latency and result.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                        input string tag);
    logic [16:0] exp;
    exp       = {1'b0, ta} + {1'b0, tb} + {16'd0, tc};
    out_ready = 1'b1;
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      check({tag, "_level"}, {29'd0, level}, lat);
      lat++;
      step();
    end
    check({tag, "_latency"}, lat, 32'd4);
    check({tag, "_sum"}, {16'd0, sum}, {16'd0, exp[15:0]});
    check({tag, "_cout"}, {31'd0, cout}, {31'd0, exp[16]});
    step();
    check({tag, "_retired"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0;
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_sum", {15'd0, cout, sum}, 32'd0);
    check("rst_level", {29'd0, level}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    run_op(16'hFFFF, 16'h0001, 1'b0, "ripple");
    run_op(16'h1234, 16'h4321, 1'b1, "carry_in");

    // Backpressure: result must hold across 6 stalled cycles.
    out_ready = 1'b0;
    a = 16'h8000; b = 16'h8000; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin lat++; step(); end
    check("bp_latency", lat, 32'd4);
    for (int i = 0; i < 6; i++) begin
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_sum", {16'd0, sum}, 32'h0000);
      check("bp_cout", {31'd0, cout}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_rise", {31'd0, in_ready}, 32'd1);
    step();
    check("bp_retired", {31'd0, out_valid}, 32'd0);

    // Back-to-back: second accept on the retire edge of the first.
    a = 16'h00FF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    step();
    a = 16'h7FFF; b = 16'h7FFF; cin = 1'b1;
    lat = 0;
    while (!out_valid && lat < 20) begin lat++; step(); end
    check("b2b1_latency", lat, 32'd4);
    check("b2b1_sum", {16'd0, sum}, 32'h0100);
    check("b2b1_cout", {31'd0, cout}, 32'd0);
    check("b2b1_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check("b2b2_no_bubble", {31'd0, busy}, 32'd1);
    check("b2b2_level0", {29'd0, level}, 32'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin lat++; step(); end
    check("b2b2_latency", lat, 32'd4);
    check("b2b2_sum", {16'd0, sum}, 32'hFFFF);
    check("b2b2_cout", {31'd0, cout}, 32'd0);
    step();

    // Reset aborts an op in progress at level 2.
    a = 16'hAAAA; b = 16'h5555; cin = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    check("abort_at_level2", {29'd0, level}, 32'd2);
    rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_level", {29'd0, level}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_out", {14'd0, out_valid, cout, sum}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    run_op(16'h0003, 16'h0005, 1'b0, "post_reset");

    // WIDTH=8: three levels.
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b1; in_valid8 = 1'b1;
    step();
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 20) begin lat++; step(); end
    check("w8_latency", lat, 32'd3);
    check("w8_sum", {24'd0, sum8}, 32'h01);
    check("w8_cout", {31'd0, cout8}, 32'd1);
    step();

    for (int n = 0; n < 1000; n++)
      run_op(16'($urandom), 16'($urandom), 1'($urandom), "rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
